// File: rtl/ex_mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: MDop bit indices,
// FSM state encodings and a small helper for lowest-bit-wins op selection.
package ex_mdu_pkg;

    localparam int MD_MULT  = 0;
    localparam int MD_MULTU = 1;
    localparam int MD_DIV   = 2;
    localparam int MD_DIVU  = 3;
    localparam int MD_MFHI  = 4;
    localparam int MD_MFLO  = 5;
    localparam int MD_MTHI  = 6;
    localparam int MD_MTLO  = 7;

    localparam int MD_OP_W  = 8;
    localparam int MD_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_t;

    // Isolates the lowest set bit so a malformed multi-hot MDop still selects one op.
    function automatic logic [MD_OP_W-1:0] md_lowest(input logic [MD_OP_W-1:0] op);
        return op & (~op + MD_OP_W'(1));
    endfunction

endpackage

// File: rtl/ex_mdu_div_core.sv
// Unsigned restoring radix-2 divider: one quotient bit per cycle, with a
// single-cycle done pulse carrying the final quotient and remainder.
module div_core
    import ex_mdu_pkg::*;
#(
    parameter int DIV_ITER = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [DIV_ITER-1:0] dividend,
    input  logic [DIV_ITER-1:0] divisor,
    output logic                done,
    output logic [DIV_ITER-1:0] quotient,
    output logic [DIV_ITER-1:0] remainder
);

    localparam int CNT_W = $clog2(DIV_ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITER - 1);

    logic [DIV_ITER-1:0] rem_q;
    logic [DIV_ITER-1:0] quo_q;
    logic [DIV_ITER-1:0] dsr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                run_q;

    logic [DIV_ITER:0]   shifted;
    logic [DIV_ITER:0]   trial;
    logic                fits;
    logic [DIV_ITER-1:0] rem_nxt;
    logic [DIV_ITER-1:0] quo_nxt;

    // Bit DIV_ITER of the trial difference is the borrow: clear means the divisor fits.
    always_comb begin
        shifted = {rem_q, quo_q[DIV_ITER-1]};
        trial   = shifted - {1'b0, dsr_q};
        fits    = ~trial[DIV_ITER];
        rem_nxt = fits ? trial[DIV_ITER-1:0] : shifted[DIV_ITER-1:0];
        quo_nxt = {quo_q[DIV_ITER-2:0], fits};
    end

    assign done      = run_q & (cnt_q == CNT_LAST);
    assign quotient  = quo_nxt;
    assign remainder = rem_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
        end else if (start) begin
            run_q <= 1'b1;
            cnt_q <= '0;
            rem_q <= '0;
            quo_q <= dividend;
            dsr_q <= divisor;
        end else if (run_q) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            if (done) begin
                run_q <= 1'b0;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit: owns HI/LO, sequences MULT/DIV through a small
// FSM and raises md_busy to stall the pipeline while an op is in flight.
module ex_mdu
    import ex_mdu_pkg::*;
#(
    parameter int DIV_ITER = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [MD_OP_W-1:0]   EX_in_MDop,
    input  logic [MD_DATA_W-1:0] EX_in_RF_rs_data,
    input  logic [MD_DATA_W-1:0] EX_in_RF_rt_data,
    input  logic                 md_cancel,
    output logic                 md_busy,
    output logic [MD_DATA_W-1:0] md_result,
    output logic [MD_DATA_W-1:0] md_hi,
    output logic [MD_DATA_W-1:0] md_lo
);

    md_state_t state;

    logic [MD_DATA_W-1:0] hi_q;
    logic [MD_DATA_W-1:0] lo_q;
    logic [MD_DATA_W-1:0] op_a;
    logic [MD_DATA_W-1:0] op_b;
    logic                 signed_q;
    logic                 div0_q;
    logic                 neg_quo_q;
    logic                 neg_rem_q;

    logic [MD_OP_W-1:0]   sel;
    logic                 is_mul;
    logic                 is_div;
    logic                 is_signed;
    logic                 start;
    logic                 div_start;

    logic [MD_DATA_W-1:0] rs_mag;
    logic [MD_DATA_W-1:0] rt_mag;

    logic [2*MD_DATA_W-1:0] mul_a;
    logic [2*MD_DATA_W-1:0] mul_b;
    logic [2*MD_DATA_W-1:0] product;

    logic                 div_done;
    logic [MD_DATA_W-1:0] div_quo;
    logic [MD_DATA_W-1:0] div_rem;
    logic [MD_DATA_W-1:0] quo_fixed;
    logic [MD_DATA_W-1:0] rem_fixed;

    always_comb begin
        sel       = md_lowest(EX_in_MDop);
        is_mul    = sel[MD_MULT] | sel[MD_MULTU];
        is_div    = sel[MD_DIV]  | sel[MD_DIVU];
        is_signed = sel[MD_MULT] | sel[MD_DIV];
        start     = rst_n & (state == ST_IDLE) & (is_mul | is_div) & ~md_cancel;
        div_start = start & is_div;
        rs_mag    = (sel[MD_DIV] && EX_in_RF_rs_data[MD_DATA_W-1]) ? -EX_in_RF_rs_data
                                                                 : EX_in_RF_rs_data;
        rt_mag    = (sel[MD_DIV] && EX_in_RF_rt_data[MD_DATA_W-1]) ? -EX_in_RF_rt_data
                                                                 : EX_in_RF_rt_data;
    end

    // Sign-extending only for MULT lets one 64-bit multiply serve both flavours.
    always_comb begin
        mul_a   = {{MD_DATA_W{signed_q & op_a[MD_DATA_W-1]}}, op_a};
        mul_b   = {{MD_DATA_W{signed_q & op_b[MD_DATA_W-1]}}, op_b};
        product = mul_a * mul_b;
    end

    div_core #(
        .DIV_ITER (DIV_ITER)
    ) u_div_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .abort     (md_cancel),
        .dividend  (rs_mag),
        .divisor   (rt_mag),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        quo_fixed = neg_quo_q ? -div_quo : div_quo;
        rem_fixed = neg_rem_q ? -div_rem : div_rem;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            op_a      <= '0;
            op_b      <= '0;
            signed_q  <= 1'b0;
            div0_q    <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (md_cancel) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_a      <= EX_in_RF_rs_data;
                        op_b      <= EX_in_RF_rt_data;
                        signed_q  <= is_signed;
                        div0_q    <= (EX_in_RF_rt_data == '0);
                        neg_quo_q <= is_signed & (EX_in_RF_rs_data[MD_DATA_W-1]
                                                  ^ EX_in_RF_rt_data[MD_DATA_W-1]);
                        neg_rem_q <= is_signed & EX_in_RF_rs_data[MD_DATA_W-1];
                        state     <= is_mul ? ST_MUL : ST_DIV;
                    end else begin
                        if (sel[MD_MTHI]) hi_q <= EX_in_RF_rs_data;
                        if (sel[MD_MTLO]) lo_q <= EX_in_RF_rs_data;
                    end
                end
                ST_MUL: begin
                    hi_q  <= product[2*MD_DATA_W-1:MD_DATA_W];
                    lo_q  <= product[MD_DATA_W-1:0];
                    state <= ST_DONE;
                end
                ST_DIV: begin
                    // Divide-by-zero is architecturally defined, not trapped.
                    if (div_done) begin
                        if (div0_q) begin
                            lo_q <= '1;
                            hi_q <= op_a;
                        end else begin
                            lo_q <= quo_fixed;
                            hi_q <= rem_fixed;
                        end
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        md_busy   = start | (state == ST_MUL) | (state == ST_DIV);
        md_result = '0;
        if (sel[MD_MFHI])      md_result = hi_q;
        else if (sel[MD_MFLO]) md_result = lo_q;
    end

    assign md_hi = hi_q;
    assign md_lo = lo_q;

endmodule
